soc_run_controller: RTL
=======================

// Module: soc_run_controller
// PURPOSE
//  Parametrised reset sequencer and run supervisor for Accellant SoC builds.
//  - Holds NUM_DOMAINS sync reset outputs, then releases them staggered.
//  - Counts run cycles and ends the run on software pass/fail or on timeout.
//  - Replaces fixed reset-pulse/cycle-limit harness logic; usable in sim top and on FPGA.
// PARAMETERS
//  NUM_DOMAINS     4        reset domains sequenced, >=1
//  HOLD_CYCLES     10       cycles all domains held in reset after rst release, >=1
//  STAGE_GAP       2        cycles between successive domain releases, >=0 (0 = all together)
//  TIMEOUT_CYCLES  1000000  RUN cycles before forced end, >=1
//  CNT_W           32       cycle_count width; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1            system clock
//  rst          in   1            asynchronous, active-low reset
//  sw_rst_req   in   1            sync pulse: restart whole sequence from HOLD
//  pass_i       in   1            software pass indication, sampled in RUN only
//  fail_i       in   1            software fail indication, sampled in RUN only
//  domain_rst   out  NUM_DOMAINS  per-domain sync reset, active-high
//  running      out  1            1 while in RUN
//  done         out  1            sticky: run has ended
//  passed       out  1            valid when done: 1 = pass_i ended the run
//  timed_out    out  1            valid when done: 1 = timeout ended the run
//  cycle_count  out  CNT_W        RUN cycles elapsed, frozen in DONE
// BEHAVIOUR
//  Reset values (rst low): state=HOLD, domain_rst=all 1, running=0, done=0, passed=0,
//   timed_out=0, cycle_count=0, internal counters=0. All outputs are registered.
//  Edge numbering: edge 1 = first posedge clk with rst high.
//  FSM HOLD -> RELEASE -> RUN -> DONE; no other transitions except sw_rst_req.
//  HOLD: domain_rst all 1 for edges 1..HOLD_CYCLES-1. At edge HOLD_CYCLES -> RELEASE.
//  RELEASE: domain_rst[i] falls at edge HOLD_CYCLES + i*STAGE_GAP. Lower index first.
//   Released bits stay 0.
//  RUN entry: same edge as domain_rst[NUM_DOMAINS-1] falls; running=1 from that edge.
//   If NUM_DOMAINS=1 or STAGE_GAP=0, HOLD goes straight to RUN at edge HOLD_CYCLES.
//  RUN: cycle_count += 1 each edge. Evaluated in priority order:
//   - fail_i=1 -> DONE, passed=0, timed_out=0 (fail beats pass on the same cycle).
//   - pass_i=1 -> DONE, passed=1, timed_out=0.
//   - cycle_count reaches TIMEOUT_CYCLES -> DONE, timed_out=1, passed=0.
//   - pass/fail on the same edge as the timeout: pass/fail wins, timed_out=0.
//  Ending edge: DONE entry sets done=1 and running=0. cycle_count includes the ending
//   edge and is frozen (never exceeds TIMEOUT_CYCLES).
//  DONE: done/passed/timed_out/cycle_count hold until rst or sw_rst_req.
//   pass_i/fail_i are ignored.
//  sw_rst_req=1 in any state, at the next edge:
//   - state=HOLD, domain_rst=all 1, all status and counters cleared to reset values.
//   - Sequence then repeats with the same timing, edge numbering restarting at that edge.
//  sw_rst_req beats pass_i/fail_i/timeout on the same edge.
//  rst low mid-sequence: immediate async return to reset values (domain_rst reasserts asynchronously).
//  pass_i/fail_i in HOLD or RELEASE are ignored, not latched.
// CONFIGURATION
//  RUN_CTRL_HALT_ON_DONE_EN defined:
//   - DONE entry reasserts domain_rst=all 1 on the ending edge; held until restart.
//  RUN_CTRL_HALT_ON_DONE_EN undefined:
//   - domain_rst stays all 0 in DONE; the SoC keeps running and only status freezes.
// TESTING  (defaults: NUM_DOMAINS=4, HOLD=10, GAP=2, small TIMEOUT=50 where noted)
//  1. Release rst, idle inputs:
//     - domain_rst 4'b1111 until edge 10.
//     - Bit0 falls @10, bit1 @12, bit2 @14, bit3 @16; running rises @16.
//  2. pass_i pulse at RUN cycle 5 -> done=1, passed=1, timed_out=0, cycle_count=5, running=0.
//  3. pass_i and fail_i high together in RUN -> done=1, passed=0, timed_out=0.
//  4. TIMEOUT=50, no pass/fail:
//     - timed_out=1, done=1, cycle_count=50 exactly.
//     - Repeat with pass_i on the 50th edge -> passed=1, timed_out=0.
//  5. sw_rst_req in RELEASE (edge 13) and again in DONE:
//     - domain_rst=4'b1111 next edge, status cleared.
//     - Bit0 falls 10 edges after the request.
//  6. Both macro builds, after pass:
//     - With RUN_CTRL_HALT_ON_DONE_EN defined -> domain_rst=4'b1111.
//     - Without it -> domain_rst=4'b0000.
//     - Also check: rst low mid-RUN clears all outputs asynchronously.

Source files
------------

// File: rtl/soc_run_controller.sv
// Reset sequencer and run supervisor: holds, then staggers release of NUM_DOMAINS resets and
// supervises the run until pass/fail/timeout. Optional build macro: RUN_CTRL_HALT_ON_DONE_EN.
module soc_run_controller #(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned HOLD_CYCLES    = 10,
  parameter int unsigned STAGE_GAP      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  input  logic                   pass_i,
  input  logic                   fail_i,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   running,
  output logic                   done,
  output logic                   passed,
  output logic                   timed_out,
  output logic [CNT_W-1:0]       cycle_count
);

  // Edge at which the last domain is released and RUN begins.
  localparam int unsigned RunEdge = HOLD_CYCLES + (NUM_DOMAINS - 1) * STAGE_GAP;

  typedef enum logic [1:0] {StHold, StRelease, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            seq_q, seq_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;
  logic                   passed_q, passed_d;
  logic                   timed_out_q, timed_out_d;
  logic [CNT_W-1:0]       cycle_count_q, cycle_count_d;
  logic [31:0]            seq_next;
  logic [CNT_W-1:0]       cnt_next;

  always_comb begin
    state_d       = state_q;
    seq_d         = seq_q;
    domain_rst_d  = domain_rst_q;
    running_d     = running_q;
    done_d        = done_q;
    passed_d      = passed_q;
    timed_out_d   = timed_out_q;
    cycle_count_d = cycle_count_q;
    seq_next      = seq_q + 32'd1;
    cnt_next      = cycle_count_q + CNT_W'(1);

    unique case (state_q)
      StHold, StRelease: begin
        // seq_next is the number of the edge being taken since (re)start.
        seq_d = seq_next;
        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
          if (seq_next >= 32'(HOLD_CYCLES) + 32'(i) * 32'(STAGE_GAP)) begin
            domain_rst_d[i] = 1'b0;
          end
        end
        if (seq_next == 32'(RunEdge)) begin
          state_d   = StRun;
          running_d = 1'b1;
        end else if (seq_next == 32'(HOLD_CYCLES)) begin
          state_d = StRelease;
        end
      end
      StRun: begin
        cycle_count_d = cnt_next;
        if (fail_i || pass_i || (cnt_next == CNT_W'(TIMEOUT_CYCLES))) begin
          state_d     = StDone;
          running_d   = 1'b0;
          done_d      = 1'b1;
          passed_d    = pass_i & ~fail_i;
          timed_out_d = ~(pass_i | fail_i);
`ifdef RUN_CTRL_HALT_ON_DONE_EN
          domain_rst_d = '1;
`else
          domain_rst_d = '0;
`endif
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StHold;
      end
    endcase

    if (sw_rst_req) begin
      state_d       = StHold;
      seq_d         = '0;
      domain_rst_d  = '1;
      running_d     = 1'b0;
      done_d        = 1'b0;
      passed_d      = 1'b0;
      timed_out_d   = 1'b0;
      cycle_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StHold;
      seq_q         <= '0;
      domain_rst_q  <= '1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      passed_q      <= 1'b0;
      timed_out_q   <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      seq_q         <= seq_d;
      domain_rst_q  <= domain_rst_d;
      running_q     <= running_d;
      done_q        <= done_d;
      passed_q      <= passed_d;
      timed_out_q   <= timed_out_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign domain_rst  = domain_rst_q;
  assign running     = running_q;
  assign done        = done_q;
  assign passed      = passed_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_count_q;

endmodule
